// File: rtl/data_mem_io_pkg.sv
// Shared address map, region type and decoder for the data memory / I/O block.
// The BERR register at 0x414 exists only when DATA_MEM_IO_BUSERR_EN is defined.
package data_mem_io_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] IO_BASE   = 32'h0000_0400;
    localparam logic [31:0] OFF_SW    = 32'h0000_0000;
    localparam logic [31:0] OFF_LED   = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE = 32'h0000_0008;
    localparam logic [31:0] OFF_TCMP  = 32'h0000_000C;
    localparam logic [31:0] OFF_TSTAT = 32'h0000_0010;
    localparam logic [31:0] OFF_BERR  = 32'h0000_0014;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SW,
        REG_LED,
        REG_CYC,
        REG_TCMP,
        REG_TSTAT,
        REG_BERR,
        REG_NONE
    } region_t;

    // Byte lane bits are dropped before matching, so every access is a whole word.
    function automatic region_t decode_region(input logic [31:0] addr, input int ram_words);
        logic [31:0] word_addr;
        logic [31:0] ram_limit;
        word_addr = {21'd0, addr[10:2], 2'b00};
        ram_limit = RAM_BASE + 32'(ram_words) * 32'd4;
        decode_region = REG_NONE;
        if (addr[31:11] == 21'd0) begin
            if (word_addr < ram_limit) begin
                decode_region = REG_RAM;
            end else begin
                case (word_addr)
                    IO_BASE + OFF_SW:    decode_region = REG_SW;
                    IO_BASE + OFF_LED:   decode_region = REG_LED;
                    IO_BASE + OFF_CYCLE: decode_region = REG_CYC;
                    IO_BASE + OFF_TCMP:  decode_region = REG_TCMP;
                    IO_BASE + OFF_TSTAT: decode_region = REG_TSTAT;
`ifdef DATA_MEM_IO_BUSERR_EN
                    IO_BASE + OFF_BERR:  decode_region = REG_BERR;
`endif
                    default:             decode_region = REG_NONE;
                endcase
            end
        end
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: asynchronous read, synchronous write, no reset.
module dmem_ram #(
    parameter int RAM_WORDS = 64
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(RAM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_io.sv
// Load/store target of the single-cycle core: word RAM plus switches, LEDs, cycle counter and timer.
// Define DATA_MEM_IO_BUSERR_EN to add the BERR register at 0x414 and the bus_err_o output.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int SW_W      = 10,
    parameter int LED_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    input  logic [SW_W-1:0]  sw_i,
    output logic [LED_W-1:0] led_o,
`ifdef DATA_MEM_IO_BUSERR_EN
    output logic             bus_err_o,
`endif
    output logic             irq_o
);

    localparam int AW = $clog2(RAM_WORDS);

    region_t          region;
    logic [31:0]      ram_rdata;
    logic             wr_ram;
    logic             wr_led;
    logic             wr_cyc;
    logic             wr_tcmp;
    logic             clr_tstat;
    logic             timer_match;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;
    logic [31:0]      tcmp_q;
    logic             tstat_q;

    assign region    = decode_region(Addr, RAM_WORDS);
    assign wr_ram    = MemWrite && (region == REG_RAM);
    assign wr_led    = MemWrite && (region == REG_LED);
    assign wr_cyc    = MemWrite && (region == REG_CYC);
    assign wr_tcmp   = MemWrite && (region == REG_TCMP);
    assign clr_tstat = MemWrite && (region == REG_TSTAT) && WriteData[0];

    dmem_ram #(
        .RAM_WORDS(RAM_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ram),
        .addr (Addr[AW+1:2]),
        .wdata(WriteData),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= WriteData[LED_W-1:0];
        end
    end

    // A software write to CYCLE restarts it from zero instead of incrementing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (wr_cyc) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcmp_q <= '0;
        end else if (wr_tcmp) begin
            tcmp_q <= WriteData;
        end
    end

    // TCMP of zero disarms the timer; a fresh match beats a same-cycle clear.
    assign timer_match = (cycle_q == tcmp_q) && (tcmp_q != 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstat_q <= 1'b0;
        end else if (timer_match) begin
            tstat_q <= 1'b1;
        end else if (clr_tstat) begin
            tstat_q <= 1'b0;
        end
    end

    assign led_o = led_q;
    assign irq_o = tstat_q;

`ifdef DATA_MEM_IO_BUSERR_EN
    logic        berr_flag;
    logic [15:0] berr_addr;
    logic        bus_fault;
    logic        clr_berr;

    // With no read strobe, any idle cycle sitting on an unmapped address counts as a faulting read.
    assign bus_fault = (region == REG_NONE) || (MemWrite && (region == REG_SW));
    assign clr_berr  = MemWrite && (region == REG_BERR) && WriteData[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            berr_flag <= 1'b0;
            berr_addr <= '0;
        end else if (bus_fault) begin
            berr_flag <= 1'b1;
            if (!berr_flag || clr_berr) begin
                berr_addr <= Addr[17:2];
            end
        end else if (clr_berr) begin
            berr_flag <= 1'b0;
            berr_addr <= '0;
        end
    end

    assign bus_err_o = berr_flag;
`endif

    always_comb begin
        ReadData = 32'd0;
        case (region)
            REG_RAM:   ReadData = ram_rdata;
            REG_SW:    ReadData = 32'(sw_sync);
            REG_LED:   ReadData = 32'(led_q);
            REG_CYC:   ReadData = cycle_q;
            REG_TCMP:  ReadData = tcmp_q;
            REG_TSTAT: ReadData = {31'd0, tstat_q};
`ifdef DATA_MEM_IO_BUSERR_EN
            REG_BERR:  ReadData = {berr_addr, 15'd0, berr_flag};
`endif
            default:   ReadData = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Randomized and directed bench for data_mem_io against a behavioural memory-map model.
// Covers the BERR register as well when DATA_MEM_IO_BUSERR_EN is defined.
module tb_data_mem_io;

    localparam int RAM_WORDS = 64;
    localparam int SW_W      = 10;
    localparam int LED_W     = 10;

    localparam int K_NONE  = 0;
    localparam int K_RAM   = 1;
    localparam int K_SW    = 2;
    localparam int K_LED   = 3;
    localparam int K_CYC   = 4;
    localparam int K_TCMP  = 5;
    localparam int K_TSTAT = 6;
    localparam int K_BERR  = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             MemWrite;
    logic [31:0]      Addr;
    logic [31:0]      WriteData;
    logic [31:0]      ReadData;
    logic [SW_W-1:0]  sw_i;
    logic [LED_W-1:0] led_o;
    logic             irq_o;
`ifdef DATA_MEM_IO_BUSERR_EN
    logic             bus_err_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]      ram_m [RAM_WORDS];
    bit               ram_ok [RAM_WORDS];
    logic [SW_W-1:0]  swa_m;
    logic [SW_W-1:0]  swb_m;
    logic [LED_W-1:0] led_m;
    logic [31:0]      cyc_m;
    logic [31:0]      tcmp_m;
    bit               tstat_m;
    bit               berr_m;
    logic [15:0]      berra_m;

    always #5 clk = ~clk;

    data_mem_io #(
        .RAM_WORDS(RAM_WORDS),
        .SW_W     (SW_W),
        .LED_W    (LED_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .sw_i     (sw_i),
        .led_o    (led_o),
`ifdef DATA_MEM_IO_BUSERR_EN
        .bus_err_o(bus_err_o),
`endif
        .irq_o    (irq_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int modelKind(input logic [31:0] a);
        logic [31:0] w;
        if (a >= 32'h800) return K_NONE;
        w = a / 4;
        if (w < RAM_WORDS) return K_RAM;
        case (w)
            32'd256: return K_SW;
            32'd257: return K_LED;
            32'd258: return K_CYC;
            32'd259: return K_TCMP;
            32'd260: return K_TSTAT;
`ifdef DATA_MEM_IO_BUSERR_EN
            32'd261: return K_BERR;
`endif
            default: return K_NONE;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, output bit known);
        int idx;
        known = 1'b1;
        idx = int'((a / 4) % RAM_WORDS);
        case (modelKind(a))
            K_RAM: begin
                known = ram_ok[idx];
                return ram_m[idx];
            end
            K_SW:    return 32'(swb_m);
            K_LED:   return 32'(led_m);
            K_CYC:   return cyc_m;
            K_TCMP:  return tcmp_m;
            K_TSTAT: return 32'(tstat_m);
            K_BERR:  return {berra_m, 15'd0, berr_m};
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        swa_m   = '0;
        swb_m   = '0;
        led_m   = '0;
        cyc_m   = '0;
        tcmp_m  = '0;
        tstat_m = 1'b0;
        berr_m  = 1'b0;
        berra_m = '0;
    endtask

    // Advance the model across one rising edge using the pre-edge state.
    task automatic modelEdge(input bit we, input logic [31:0] a, input logic [31:0] d);
        int          k;
        bit          hit;
        logic [31:0] next_cyc;
        k        = modelKind(a);
        hit      = (cyc_m == tcmp_m) && (tcmp_m != 0);
        next_cyc = cyc_m + 1;
        if (we) begin
            case (k)
                K_RAM: begin
                    ram_m[int'((a / 4) % RAM_WORDS)]  = d;
                    ram_ok[int'((a / 4) % RAM_WORDS)] = 1'b1;
                end
                K_LED:   led_m = d[LED_W-1:0];
                K_CYC:   next_cyc = 0;
                K_TCMP:  tcmp_m = d;
                K_TSTAT: if (d[0]) tstat_m = 1'b0;
                K_BERR: begin
                    if (d[0]) begin
                        berr_m  = 1'b0;
                        berra_m = '0;
                    end
                end
                default: ;
            endcase
        end
        if (hit) tstat_m = 1'b1;
        if ((k == K_NONE || (we && k == K_SW)) && !berr_m) begin
            berr_m  = 1'b1;
            berra_m = a[17:2];
        end
        cyc_m = next_cyc;
        swb_m = swa_m;
        swa_m = sw_i;
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] expected;
        bit          known;
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        @(negedge clk);
        expected = modelRead(a, known);
        if (known) checkOutput($sformatf("read@%08h", a), ReadData, expected);
        @(posedge clk);
        modelEdge(we, a, d);
        #1;
        checkOutput("led_o", 32'(led_o), 32'(led_m));
        checkOutput("irq_o", 32'(irq_o), 32'(tstat_m));
`ifdef DATA_MEM_IO_BUSERR_EN
        checkOutput("bus_err_o", 32'(bus_err_o), 32'(berr_m));
`endif
    endtask

    task automatic resetDut();
        #2;
        MemWrite = 1'b0;
        Addr     = 32'h408;
        reset    = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_led", 32'(led_o), 32'd0);
        checkOutput("rst_irq", 32'(irq_o), 32'd0);
        checkOutput("rst_cycle", ReadData, 32'd0);
`ifdef DATA_MEM_IO_BUSERR_EN
        checkOutput("rst_bus_err", 32'(bus_err_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        Addr      = 32'h0;
        WriteData = 32'h0;
        sw_i      = '0;
        for (int i = 0; i < RAM_WORDS; i++) ram_ok[i] = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        resetDut();

        repeat (5) applyStimulus(1'b0, 32'h408, 32'h0);
        checkOutput("cycle_after_5", ReadData, 32'd5);
        applyStimulus(1'b1, 32'h408, 32'h0000_ABCD);
        checkOutput("cycle_cleared", ReadData, 32'd0);
        applyStimulus(1'b0, 32'h408, 32'h0);
        checkOutput("cycle_restart", ReadData, 32'd1);

        applyStimulus(1'b1, 32'h010, 32'h1111_1111);
        applyStimulus(1'b1, 32'h010, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h013, 32'h0);
        checkOutput("ram_byte_bits", ReadData, 32'hDEAD_BEEF);

        sw_i = 10'h2A5;
        applyStimulus(1'b0, 32'h400, 32'h0);
        checkOutput("sw_one_edge", ReadData, 32'h0);
        applyStimulus(1'b1, 32'h400, 32'hFFFF_FFFF);
        checkOutput("sw_two_edges", ReadData, 32'h0000_02A5);

        applyStimulus(1'b1, 32'h404, 32'hFFFF_F155);
        checkOutput("led_value", 32'(led_o), 32'h155);
        checkOutput("led_read", ReadData, 32'h0000_0155);

        applyStimulus(1'b0, 32'h800, 32'h0);
        checkOutput("unmapped_read", ReadData, 32'h0);
`ifdef DATA_MEM_IO_BUSERR_EN
        applyStimulus(1'b1, 32'h414, 32'h1);
        checkOutput("berr_cleared", 32'(bus_err_o), 32'd0);
        applyStimulus(1'b0, 32'h800, 32'h0);
        applyStimulus(1'b0, 32'h414, 32'h0);
        checkOutput("berr_flag", 32'(bus_err_o), 32'd1);
        checkOutput("berr_addr", 32'(ReadData[31:16]), 32'h0200);
`endif

        resetDut();
        applyStimulus(1'b0, 32'h010, 32'h0);
        checkOutput("ram_retained", ReadData, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 32'h40C, 32'd20);
        for (int i = 0; i < 40 && cyc_m != 32'd20; i++) applyStimulus(1'b0, 32'h410, 32'h0);
        checkOutput("irq_before_match", 32'(irq_o), 32'd0);
        applyStimulus(1'b0, 32'h410, 32'h0);
        checkOutput("irq_at_match", 32'(irq_o), 32'd1);
        checkOutput("tstat_read", ReadData, 32'd1);
        applyStimulus(1'b1, 32'h410, 32'h1);
        checkOutput("irq_cleared", 32'(irq_o), 32'd0);

        applyStimulus(1'b1, 32'h40C, 32'h0);
        applyStimulus(1'b1, 32'h408, 32'h0);
        repeat (4) applyStimulus(1'b0, 32'h410, 32'h0);
        checkOutput("irq_tcmp_zero", 32'(irq_o), 32'd0);

        applyStimulus(1'b1, 32'h40C, cyc_m + 32'd3);
        for (int i = 0; i < 10 && !tstat_m; i++) applyStimulus(1'b0, 32'h40C, 32'h0);
        checkOutput("irq_set_again", 32'(irq_o), 32'd1);
        applyStimulus(1'b1, 32'h40C, cyc_m + 32'd2);
        for (int i = 0; i < 10 && cyc_m != tcmp_m; i++) applyStimulus(1'b0, 32'h40C, 32'h0);
        applyStimulus(1'b1, 32'h410, 32'h1);
        checkOutput("irq_clear_vs_match", 32'(irq_o), 32'd1);

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
                4: a = 32'h400;
                5: a = 32'h404;
                6: a = 32'h408;
                7: begin
                    a = 32'h40C;
                    d = cyc_m + 32'($urandom_range(1, 6));
                end
                8: a = 32'h410;
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h800 + ($urandom & 32'h000F_FFFC);
                        1: a = 32'h414;
                        2: a = 32'h418 + 32'($urandom_range(0, 30)) * 4;
                        default: a = RAM_WORDS * 4 + 32'($urandom_range(0, 100)) * 4;
                    endcase
                end
            endcase
            if ($urandom_range(0, 7) == 0) sw_i = SW_W'($urandom);
            applyStimulus(we, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
